time_keeper: RTL and testbench

TIME_KEEPER -- requirements
Module: time_keeper

---
 rtl/time_keeper.sv | 133 +++++++++++++
 tb/tb_time_keeper.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_keeper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : time_keeper
// Purpose  : MM:SS BCD clock with a one-second prescaler, run/stop/set FSM
//            and push-button editing of the seconds or minutes field.
// Revision : 1.0 - initial release
// ============================================================================
module time_keeper #(
    parameter int TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       set_mode,
    input  logic       inc,
    input  logic       sel,
    output logic [3:0] current0,
    output logic [3:0] current1,
    output logic [3:0] current2,
    output logic [3:0] current3,
    output logic       tick,
    output logic       rollover,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        STOP = 2'b00,
        RUN  = 2'b01,
        SET  = 2'b10
    } state_t;

    localparam logic [25:0] PRESC_LAST = 26'(TICK_DIV - 1);

    state_t      state_q;
    state_t      state_d;
    logic        count_en;
    logic        edit_en;
    logic        sec_due;
    logic [25:0] prescaler;
    logic [8:0]  sec_inc;
    logic [8:0]  min_inc;
    logic [3:0]  d0_n, d1_n, d2_n, d3_n;

    // Increment a 00..59 BCD pair; bit 8 flags the 59 -> 00 wrap.
    function automatic logic [8:0] bcd60_inc(input logic [3:0] tens, input logic [3:0] ones);
        logic [8:0] r;
        if (ones == 4'd9) begin
            if (tens == 4'd5) r = {1'b1, 4'd0, 4'd0};
            else              r = {1'b0, tens + 4'd1, 4'd0};
        end else begin
            r = {1'b0, tens, ones + 4'd1};
        end
        return r;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= STOP;
        else        state_q <= state_d;
    end

    // Next-state decode plus the counting / editing qualifiers.
    // Counting needs RUN both now and next, so leaving RUN halts at once and
    // the first RUN cycle starts the prescaler from zero. Editing follows the
    // next state so an inc coinciding with the set_mode rise is honoured.
    always_comb begin
        state_d  = STOP;
        count_en = 1'b0;
        edit_en  = 1'b0;
        if (set_mode)  state_d = SET;
        else if (run)  state_d = RUN;
        count_en = (state_q == RUN) && (state_d == RUN);
        edit_en  = (state_d == SET) && inc;
    end

    assign state   = state_q;
    assign sec_due = count_en && (prescaler == PRESC_LAST);
    assign sec_inc = bcd60_inc(current1, current0);
    assign min_inc = bcd60_inc(current3, current2);

    // Next digit values: a tick carries seconds into minutes, edits do not.
    always_comb begin
        d0_n = current0;
        d1_n = current1;
        d2_n = current2;
        d3_n = current3;
        if (sec_due) begin
            d1_n = sec_inc[7:4];
            d0_n = sec_inc[3:0];
            if (sec_inc[8]) begin
                d3_n = min_inc[7:4];
                d2_n = min_inc[3:0];
            end
        end else if (edit_en) begin
            if (!sel) begin
                d1_n = sec_inc[7:4];
                d0_n = sec_inc[3:0];
            end else begin
                d3_n = min_inc[7:4];
                d2_n = min_inc[3:0];
            end
        end
    end

    // Prescaler: free-runs only while counting, otherwise held at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                        prescaler <= '0;
        else if (!count_en || sec_due)     prescaler <= '0;
        else                               prescaler <= prescaler + 26'd1;
    end

    // Digit registers and the one-cycle tick / rollover strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            current0 <= 4'd0;
            current1 <= 4'd0;
            current2 <= 4'd0;
            current3 <= 4'd0;
            tick     <= 1'b0;
            rollover <= 1'b0;
        end else begin
            current0 <= d0_n;
            current1 <= d1_n;
            current2 <= d2_n;
            current3 <= d3_n;
            tick     <= sec_due;
            rollover <= sec_due && sec_inc[8] && min_inc[8];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_time_keeper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_time_keeper
// Purpose  : Randomised + directed scoreboard bench for time_keeper, with a
//            reference model that keeps the time as total seconds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_time_keeper;

    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       run = 1'b0;
    logic       set_mode = 1'b0;
    logic       inc = 1'b0;
    logic       sel = 1'b0;
    logic [3:0] current0, current1, current2, current3;
    logic       tick, rollover;
    logic [1:0] state;

    time_keeper #(.TICK_DIV(TICK_DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .set_mode (set_mode),
        .inc      (inc),
        .sel      (sel),
        .current0 (current0),
        .current1 (current1),
        .current2 (current2),
        .current3 (current3),
        .tick     (tick),
        .rollover (rollover),
        .state    (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] d3;
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
        logic       tk;
        logic       ro;
        logic [1:0] st;
    } obs_t;

    obs_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: time as seconds 0..3599, mode 0 STOP / 1 RUN / 2 SET,
    // phase = cycles elapsed in the current uninterrupted RUN stretch.
    int m_secs  = 0;
    int m_phase = 0;
    int m_mode  = 0;

    function automatic obs_t model_view(input int secs, input int tk, input int ro, input int mode);
        obs_t o;
        int s;
        int m;
        s = secs % 60;
        m = secs / 60;
        o.d0 = 4'(s % 10);
        o.d1 = 4'(s / 10);
        o.d2 = 4'(m % 10);
        o.d3 = 4'(m / 10);
        o.tk = (tk != 0);
        o.ro = (ro != 0);
        o.st = 2'(mode);
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.d0 = current0;
        o.d1 = current1;
        o.d2 = current2;
        o.d3 = current3;
        o.tk = tick;
        o.ro = rollover;
        o.st = state;
        return o;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h%h:%h%h tick=%b roll=%b state=%b, required %h%h:%h%h tick=%b roll=%b state=%b",
                     name, $time, got.d3, got.d2, got.d1, got.d0, got.tk, got.ro, got.st,
                     want.d3, want.d2, want.d1, want.d0, want.tk, want.ro, want.st);
        end
    endtask

    // Advance the model by one clock edge with the given inputs.
    task automatic model_step(input int r, input int sm, input int ic, input int sl);
        int nmode;
        int tk;
        int ro;
        tk = 0;
        ro = 0;
        nmode = (sm != 0) ? 2 : ((r != 0) ? 1 : 0);
        if (m_mode == 1 && nmode == 1) begin
            m_phase++;
            if (m_phase == TICK_DIV) begin
                m_phase = 0;
                tk = 1;
                ro = (m_secs == 3599) ? 1 : 0;
                m_secs = (m_secs + 1) % 3600;
            end
        end else begin
            m_phase = 0;
            if (nmode == 2 && ic != 0) begin
                if (sl == 0) m_secs = (m_secs / 60) * 60 + ((m_secs % 60) + 1) % 60;
                else         m_secs = (m_secs + 60) % 3600;
            end
        end
        m_mode = nmode;
        exp_q.push_back(model_view(m_secs, tk, ro, m_mode));
    endtask

    task automatic cycle(input int r, input int sm, input int ic, input int sl);
        @(negedge clk);
        run      = (r != 0);
        set_mode = (sm != 0);
        inc      = (ic != 0);
        sel      = (sl != 0);
        model_step(r, sm, ic, sl);
    endtask

    // Drive reset low between edges and confirm the digits clear immediately.
    task automatic async_reset_check(input string name);
        cycle(0, 0, 0, 0);
        @(posedge clk);
        #3 reset = 1'b0;
        #1 check(name, dut_obs(), model_view(0, 0, 0, 0));
        m_secs  = 0;
        m_phase = 0;
        m_mode  = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic set_time(input int mm, input int ss);
        int dm;
        int ds;
        cycle(0, 1, 0, 0);
        dm = (mm - m_secs / 60 + 60) % 60;
        ds = (ss - m_secs % 60 + 60) % 60;
        repeat (dm) begin cycle(0, 1, 1, 1); cycle(0, 1, 0, 1); end
        repeat (ds) begin cycle(0, 1, 1, 0); cycle(0, 1, 0, 0); end
        cycle(0, 0, 0, 0);
    endtask

    // Monitor: one expected entry per clock edge, compared just after it.
    initial begin : monitor
        obs_t want;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                check("scoreboard", dut_obs(), want);
            end
        end
    end

    // Stimulus.
    initial begin : stimulus
        int r;
        int sm;
        int ic;
        int sl;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1 check("reset_state", dut_obs(), model_view(0, 0, 0, 0));
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Continuous run: ten ticks, one every TICK_DIV cycles.
        repeat (41) cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        @(posedge clk);
        #2 check("run_ten_ticks", dut_obs(), model_view(10, 0, 0, 0));

        // Set 59:59 from 00:00 by button presses, then wrap.
        async_reset_check("reset_before_wrap");
        cycle(0, 1, 0, 1);
        repeat (59) begin cycle(0, 1, 1, 1); cycle(0, 1, 0, 1); end
        cycle(0, 1, 0, 0);
        repeat (59) begin cycle(0, 1, 1, 0); cycle(0, 1, 0, 0); end
        repeat (6) cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);

        // Carry boundaries.
        set_time(0, 9);
        repeat (6) cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        set_time(9, 59);
        repeat (6) cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);

        // Seconds edit wraps without carry; inc ignored outside SET.
        set_time(0, 59);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 1, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(1, 0, 1, 1);
        cycle(0, 0, 0, 0);

        // inc in the very cycle set_mode rises.
        cycle(0, 1, 1, 1);
        cycle(0, 0, 0, 0);

        // Partial second discarded by a one-cycle set_mode pulse.
        repeat (3) cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        repeat (9) cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);

        // Asynchronous reset at 12:34.
        set_time(12, 34);
        async_reset_check("async_reset_1234");

        // Randomised operation near the wrap point.
        set_time(59, 50);
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(7, 0) != 0) ? 1 : 0;
            sm = ($urandom_range(11, 0) == 0) ? 1 : 0;
            ic = ($urandom_range(2, 0) == 0) ? 1 : 0;
            sl = ($urandom_range(1, 0) == 1) ? 1 : 0;
            cycle(r, sm, ic, sl);
            if ($urandom_range(999, 0) == 0) async_reset_check("random_reset");
        end
        cycle(0, 0, 0, 0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        #2;
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
